// File: rtl/ez_logic_top.sv
// ez_logic_top: byte stream scrambler (XOR with an LFSR key, rotate left 3, chain-add the previous output)
module ez_logic_top (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out
);
  localparam logic IDLE = 1'b0;
  localparam logic ACTIVE = 1'b1;
  logic       state;
  logic [7:0] k, c, t, y;
  always_comb begin
    t = data_in ^ k;
    y = {t[4:0], t[7:5]} + c;
  end
  // ACTIVE exactly when the previous edge accepted a byte, which is what valid_out reports
  assign valid_out = state == ACTIVE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_out <= 8'h00;
      k        <= 8'hA5;
      c        <= 8'h00;
    end else begin
      state    <= valid_in ? ACTIVE : IDLE;
      data_out <= valid_in ? y : 8'h00;
      if (valid_in) begin
        c <= y;
        k <= {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
      end
    end
  end
endmodule

// File: tb/tb_ez_logic_top.sv
// tb_ez_logic_top: scoreboard bench; stimulus pushes expected bytes and arrival cycles, a negedge monitor checks them
module tb_ez_logic_top;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       valid_out;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_valid = 0;
  bit         armed = 1'b0;
  logic [7:0] exp_d[$];
  int         exp_t[$];
  logic [7:0] mk = 8'hA5;
  logic [7:0] mc = 8'h00;
  logic [7:0] ed;
  int         et;

  ez_logic_top dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model_y(input logic [7:0] d, input logic [7:0] k, input logic [7:0] c);
    logic [7:0] t, r;
    t = d ^ k;
    r = {t[4:0], t[7:5]};
    return r + c;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (valid_out === 1'b1) begin
        n_valid++;
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %02h want no output (cycle %0d)", data_out, cyc);
        end else begin
          ed = exp_d.pop_front();
          et = exp_t.pop_front();
          check8("data_out", data_out, ed);
          check_int("out_cycle", cyc, et);
        end
      end else begin
        check8("idle_valid", {7'd0, valid_out}, 8'h00);
        check8("idle_data", data_out, 8'h00);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] exp);
    @(posedge clk);
    #1;
    data_in  = d;
    valid_in = 1'b1;
    exp_d.push_back(exp);
    exp_t.push_back(cyc + 1);
    mc = model_y(d, mk, mc);
    mk = {mk[6:0], mk[7] ^ mk[5] ^ mk[4] ^ mk[3]};
  endtask

  task automatic send_model(input logic [7:0] d);
    send(d, model_y(d, mk, mc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic do_reset(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    mk       = 8'hA5;
    mc       = 8'h00;
    armed    = 1'b1;
    check8("rst_valid", {7'd0, valid_out}, 8'h00);
    check8("rst_data", data_out, 8'h00);
  endtask

  initial begin
    int start;
    do_reset(1'b0, 8'h00);
    // single byte
    send(8'h00, 8'h2D);
    idle(2);
    // back-to-back
    do_reset(1'b0, 8'h00);
    send(8'h00, 8'h2D);
    check8("k_after_first", mk, 8'h4A);
    send(8'h00, 8'h7F);
    idle(2);
    // ASCII prefix
    do_reset(1'b0, 8'h00);
    send(8'h66, 8'h1E);
    send(8'h6C, 8'h4F);
    idle(2);
    // idle gap of 3 cycles; arrival-cycle check enforces the gap length
    do_reset(1'b0, 8'h00);
    send(8'h66, 8'h1E);
    idle(3);
    send(8'h6C, 8'h4F);
    idle(2);
    // reset mid-stream with a byte presented during reset
    do_reset(1'b0, 8'h00);
    send(8'h00, 8'h2D);
    send(8'h00, 8'h7F);
    do_reset(1'b1, 8'h55);
    send(8'h00, 8'h2D);
    idle(2);
    // long stream
    do_reset(1'b0, 8'h00);
    start = n_valid;
    for (int i = 0; i < 42; i++) send_model(8'((i * 37 + 13) & 8'hFF));
    idle(3);
    check_int("long_count", n_valid - start, 42);
    for (int i = 0; i < 50 && exp_d.size() != 0; i++) @(posedge clk);
    check_int("queue_empty", exp_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ez_logic_top.md
EZ_LOGIC_TOP -- requirements
Module: ez_logic_top

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port data_in, input, 8 bits: plaintext byte.
REQ-004 SHALL have port valid_in, input, 1 bit: data_in is valid this cycle; no backpressure, so every valid byte is accepted.
REQ-005 SHALL have port data_out, output, 8 bits: transformed byte.
REQ-006 SHALL have port valid_out, output, 1 bit: data_out is valid this cycle.
REQ-007 SHALL have no parameters: byte width is fixed at 8, and stream length is unbounded.

Function
REQ-008 SHALL hold internal state:
- key register k, 8 bits, reset value 0xA5;
- chain register c, 8 bits, reset value 0x00.
REQ-009 SHALL compute the combinational result y from the current data_in, k and c:
- t = data_in XOR k;
- r = t rotated left by 3 bits, so r = {t[4:0], t[7:5]};
- y = (r + c) mod 256, with the carry discarded.
REQ-010 SHALL, on a rising edge with valid_in=1 and rst=0, perform all of the following:
- data_out <= y;
- valid_out <= 1;
- c <= y;
- k <= {k[6:0], k[7]^k[5]^k[4]^k[3]}, a Fibonacci LFSR step.
REQ-011 SHALL, on a rising edge with valid_in=0 and rst=0:
- drive valid_out <= 0 and data_out <= 0x00;
- leave k and c unchanged, so idle gaps do not alter the transform of later bytes.
REQ-012 SHALL give latency of exactly one cycle: a byte accepted at edge n appears on data_out/valid_out during the cycle after edge n.
REQ-013 SHALL sustain one byte per cycle when valid_in is held high, with valid_out high for the same number of consecutive cycles.
REQ-014 SHALL emit output bytes in input order, with exactly one output per accepted input and none dropped or duplicated.
REQ-015 SHALL use a 2-state controller:
- IDLE -> ACTIVE on valid_in=1;
- ACTIVE -> IDLE on valid_in=0;
- ACTIVE marks that the last accepted byte produced output;
- the state drives no behaviour other than what is specified above.
REQ-016 SHALL never reach an all-zero k: the reset seed is nonzero and the LFSR preserves nonzero state.

Reset
REQ-017 SHALL, on a rising edge with rst=1, set data_out=0x00, valid_out=0, k=0xA5, c=0x00 and state=IDLE.
REQ-018 SHALL give rst priority over valid_in: a byte presented in the same cycle as rst=1 is discarded and produces no output.
REQ-019 SHALL allow reset mid-stream: after rst deasserts, the next accepted byte is transformed exactly as the first byte after power-up.
REQ-020 SHALL treat output values before the first reset as don't-care; the bench applies reset before any stimulus.

Verification
REQ-021 Single byte: reset, then data_in=0x00 for one cycle -> next cycle valid_out=1 and data_out=0x2D, then valid_out=0 and data_out=0x00.
REQ-022 Back-to-back stream: after reset, send 0x00, 0x00 on consecutive cycles -> outputs 0x2D then 0x7F on consecutive cycles, with k=0x4A after the first byte.
REQ-023 ASCII prefix: after reset, send 0x66 ('f') then 0x6C ('l') -> outputs 0x1E then 0x4F.
REQ-024 Idle gap: after reset, send 0x66, hold valid_in=0 for 3 cycles, then send 0x6C -> outputs 0x1E then 0x4F, with valid_out low for exactly the 3 gap cycles.
REQ-025 Reset mid-stream: send 0x00, 0x00, assert rst for one cycle with valid_in=1 and data_in=0x55, then send 0x00 -> outputs 0x2D, 0x7F, no output for 0x55, then 0x2D.
REQ-026 Long stream: 42 consecutive bytes -> exactly 42 valid_out pulses in order, each matching a bit-exact software model of REQ-009/REQ-010, including wrap of the addition in y past 0xFF.
